// File: rtl/axi_sync_pkg.sv
// Shared definitions for the AW/W burst synchroniser.
package axi_sync_pkg;

  localparam int unsigned LEN_WIDTH = 8;

  // Burst-tracking state: waiting for an AW, or forwarding W beats of a burst.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

endpackage

// File: rtl/axi_aw_w_sync.sv
// Holds back W beats until the AW of their burst has been handshaken downstream,
// counts aw_len+1 beats per burst, regenerates WLAST from the count, and lets at
// most one further AW be accepted ahead of the burst in flight.
module axi_aw_w_sync
  import axi_sync_pkg::*;
#(
  parameter int unsigned AW_WIDTH = 64,
  parameter int unsigned W_WIDTH  = 72
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Upstream AW
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AW_WIDTH-1:0]  aw_data_i,
  input  logic [LEN_WIDTH-1:0] aw_len_i,
  // Upstream W
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [W_WIDTH-1:0]   w_data_i,
  input  logic                 w_last_i,
  // Downstream AW
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AW_WIDTH-1:0]  aw_data_o,
  output logic [LEN_WIDTH-1:0] aw_len_o,
  // Downstream W
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [W_WIDTH-1:0]   w_data_o,
  output logic                 w_last_o,
  // Status
  output logic                 busy_o,
  output logic                 err_o
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [LEN_WIDTH-1:0] pend_len_q, pend_len_d;
  logic                 err_q, err_d;

  logic in_data;
  logic last_beat;
  logic aw_hs;
  logic w_hs;

  // Channel steering: AW passes through unless a burst is already pending,
  // W is gated off entirely until a burst is open.
  always_comb begin
    in_data    = (state_q == DATA);
    last_beat  = (cnt_q == '0);

    aw_data_o  = aw_data_i;
    aw_len_o   = aw_len_i;
    w_data_o   = w_data_i;

    aw_valid_o = aw_valid_i & ~(in_data & pend_valid_q);
    aw_ready_o = aw_ready_i & ~(in_data & pend_valid_q);
    w_valid_o  = in_data & w_valid_i;
    w_ready_o  = in_data & w_ready_i;
    w_last_o   = in_data & last_beat;

    aw_hs      = aw_valid_i & aw_ready_o;
    w_hs       = w_valid_i & w_ready_o;

    busy_o     = in_data;
    err_o      = err_q;
  end

  // Next-state: beat counting, pending-AW bookkeeping and WLAST checking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_len_d   = pend_len_q;
    err_d        = 1'b0;

    if (!in_data) begin
      if (aw_hs) begin
        cnt_d   = aw_len_i;
        state_d = DATA;
      end
    end else begin
      // aw_hs can only occur here with no pending entry (ready is masked).
      if (aw_hs && !(w_hs && last_beat)) begin
        pend_valid_d = 1'b1;
        pend_len_d   = aw_len_i;
      end

      if (w_hs) begin
        // Upstream WLAST is only checked; the count alone delimits the burst.
        err_d = (w_last_i != last_beat);
        if (!last_beat) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_valid_q) begin
          cnt_d        = pend_len_q;
          pend_valid_d = 1'b0;
        end else if (aw_hs) begin
          cnt_d = aw_len_i;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // State registers with synchronous reset; reset drops any open or pending burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_len_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_len_q   <= pend_len_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/axi_aw_w_sync.md
AXI_AW_W_SYNC -- requirements
Module: axi_aw_w_sync

Interface
REQ-001 SHALL have parameter AW_WIDTH, default 64: width of the packed AW payload excluding burst length.
REQ-002 SHALL have parameter W_WIDTH, default 72: width of the packed W payload excluding last.
REQ-003 SHALL have port clk_i, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports aw_valid_i/aw_ready_o/aw_data_i[AW_WIDTH]/aw_len_i[8]: upstream AW channel.
REQ-006 SHALL have ports w_valid_i/w_ready_o/w_data_i[W_WIDTH]/w_last_i[1]: upstream W channel.
REQ-007 SHALL have ports aw_valid_o/aw_ready_i/aw_data_o[AW_WIDTH]/aw_len_o[8]: downstream AW channel.
REQ-008 SHALL have ports w_valid_o/w_ready_i/w_data_o[W_WIDTH]/w_last_o[1]: downstream W channel.
REQ-009 SHALL have outputs busy_o[1] (burst in progress) and err_o[1] (one-cycle pulse on WLAST mismatch).

Function
REQ-010 SHALL forward W beats only after the AW of their burst has been handshaken downstream; each burst carries aw_len+1 beats.
REQ-011 SHALL implement states IDLE and DATA, plus a beat counter cnt_q[8] and a one-entry pending-length register (pend_valid_q, pend_len_q).
REQ-012 SHALL, in IDLE: aw_valid_o=aw_valid_i, aw_ready_o=aw_ready_i, w_valid_o=0, w_ready_o=0.
REQ-013 SHALL, in IDLE on an AW handshake: cnt_q<=aw_len_i, go to DATA; zero-cycle AW latency, first W forwardable the next cycle.
REQ-014 SHALL, in DATA: w_valid_o=w_valid_i, w_ready_o=w_ready_i, w_last_o=(cnt_q==0), w_data_o=w_data_i.
REQ-015 SHALL, in DATA: aw_valid_o=aw_valid_i&~pend_valid_q, aw_ready_o=aw_ready_i&~pend_valid_q; an AW handshake without a concurrent final-beat handshake stores aw_len_i into the pending register.
REQ-016 SHALL pass aw_data_i/aw_len_i to aw_data_o/aw_len_o combinationally in all states.
REQ-017 SHALL, on a non-final W handshake (cnt_q!=0), decrement cnt_q by 1.
REQ-018 SHALL, on the final W handshake (cnt_q==0): if pend_valid_q, load cnt_q<=pend_len_q, clear pending, stay in DATA; else if a simultaneous AW handshake occurs, load cnt_q<=aw_len_i, stay in DATA; else go to IDLE.
REQ-019 SHALL, on any W handshake where w_last_i!=(cnt_q==0), assert err_o (registered) for exactly the following cycle; beat counting is unaffected by w_last_i.
REQ-020 SHALL drive busy_o=1 in DATA, 0 in IDLE.
REQ-021 SHALL not allow more than one AW ahead of the current burst: with pend_valid_q=1, aw_ready_o=0.
REQ-022 SHALL support aw_len_i=0 (single beat) and aw_len_i=255 (256 beats) without wrap errors.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, set state=IDLE, cnt_q=0, pend_valid_q=0, pend_len_q=0, err_o=0.
REQ-024 SHALL, after reset, drive busy_o=0, w_valid_o=0, w_ready_o=0; reset mid-burst discards the burst and pending entry.

Structure
REQ-025 SHALL place the state enum (IDLE, DATA) and LEN_WIDTH=8 in shared package axi_sync_pkg.
REQ-026 SHALL be a single module with no sub-modules; it is intended to sit downstream of two axi_single_slice instances (AW and W).

Verification
REQ-027 SHALL cover: AW len=3, W valid held -> 4 W beats forwarded, w_last_o only on beat 4, return to IDLE, err_o never set.
REQ-028 SHALL cover: W valid before AW -> w_ready_o=0, w_valid_o=0 until the cycle after the AW handshake.
REQ-029 SHALL cover: AW len=1 then AW len=0 during the first burst -> second AW accepted and pended, third AW stalled (aw_ready_o=0), 3 beats total with no idle cycle between bursts.
REQ-030 SHALL cover: AW len=2 with w_last_i=1 on beat 2 -> err_o high one cycle, w_last_o still asserted only on beat 3.
REQ-031 SHALL cover: AW len=255 -> exactly 256 beats, cnt_q counts 255..0, last on beat 256.
REQ-032 SHALL cover: rst_i=1 during beat 2 of len=7 burst -> next cycle busy_o=0, w_ready_o=0, new AW accepted normally.
